// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
//   - opcode constants for the supported instructions
//   - FSM state encoding (4-bit binary, 13 states)
//   - ALUOp, ALU B-select and PC-source encodings
//   - ctrl_t: bundle of per-state control outputs
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcWrite;
    logic       branch;
    logic       irWrite;
    logic       iord;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic       regDst;
    logic       memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSrc;
    logic       instrDone;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle.
//   op, mem_ready        : datapath -> control (opcode field, memory done)
//   all other signals    : control -> datapath (enables, selects, ALUOp,
//                          retire pulse, sticky trap flag)
// master = control unit side, slave = datapath side.
interface multicycle_control_unit_if #(parameter int OP_WIDTH = 6);
  logic [OP_WIDTH-1:0] op;
  logic                mem_ready;
  logic                pc_write;
  logic                branch;
  logic                ir_write;
  logic                iord;
  logic                mem_read;
  logic                mem_write;
  logic                reg_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic [1:0]          pc_src;
  logic                instr_done;
  logic                illegal_op;

  modport master (
    input  op, mem_ready,
    output pc_write, branch, ir_write, iord, mem_read, mem_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, pc_src, instr_done, illegal_op
  );

  modport slave (
    output op, mem_ready,
    input  pc_write, branch, ir_write, iord, mem_read, mem_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, pc_src, instr_done, illegal_op
  );
endinterface

// File: rtl/mc_output_decode.sv
// Combinational Moore output decode for the multicycle control FSM.
//   state       : current FSM state
//   memReady    : memory handshake (gates FETCH writes, MEMWR retire)
//   skipIllegal : DECODE is retiring an illegal op as a NOP
//   ctrl        : control outputs (illegal_op is handled by the top)
module mc_output_decode
  import mips_mc_pkg::*;
(
  input  state_t state,
  input  logic   memReady,
  input  logic   skipIllegal,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = SRCB_FOUR;
        ctrl.aluOp   = ALU_ADD;
        ctrl.pcSrc   = PC_ALU;
        // IR and PC only load once the instruction word is actually there
        ctrl.irWrite = memReady;
        ctrl.pcWrite = memReady;
      end
      S_DECODE: begin
        ctrl.aluSrcB   = SRCB_IMMSH2;
        ctrl.aluOp     = ALU_ADD;
        ctrl.instrDone = skipIllegal;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.iord    = 1'b1;
        ctrl.memRead = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regWrite  = 1'b1;
        ctrl.memToReg  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.memWrite  = 1'b1;
        ctrl.instrDone = memReady;
      end
      S_EXECUTE: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_RT;
        ctrl.aluOp   = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regWrite  = 1'b1;
        ctrl.regDst    = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      S_BRANCH: begin
        ctrl.aluSrcA   = 1'b1;
        ctrl.aluSrcB   = SRCB_RT;
        ctrl.aluOp     = ALU_SUB;
        ctrl.pcSrc     = PC_ALUOUT;
        ctrl.branch    = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.regWrite  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcSrc     = PC_JUMP;
        ctrl.pcWrite   = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: Moore FSM sequencing each instruction over
// several cycles on a shared ALU / memory port.
//   clk, reset : clock, synchronous active-high reset
//   bus        : master side of multicycle_control_unit_if (op, mem_ready in;
//                datapath controls, instr_done, illegal_op out)
// Keeps the state register, the opcode captured in DECODE and the sticky
// trap flag; output decode lives in mc_output_decode.
module multicycle_control_unit
  import mips_mc_pkg::*;
#(
  parameter int OP_WIDTH        = 6,
  parameter bit HAS_JUMP        = 1'b1,
  parameter bit HAS_ADDI        = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  multicycle_control_unit_if.master  bus
);

  state_t              state, nextState, decodeTarget;
  logic [OP_WIDTH-1:0] opReg;
  logic                trapFlag;
  logic                opLegal;
  logic                skipIllegal;
  ctrl_t               ctrl, ctrlQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      opReg    <= '0;
      trapFlag <= 1'b0;
    end else begin
      state <= nextState;
      // MEMADR needs to know lw vs sw after op has moved on
      if (state == S_DECODE) opReg <= bus.op;
      if (nextState == S_TRAP) trapFlag <= 1'b1;
    end
  end

  always_comb begin
    decodeTarget = S_FETCH;
    opLegal      = 1'b1;
    case (bus.op)
      OP_WIDTH'(OP_LW), OP_WIDTH'(OP_SW): decodeTarget = S_MEMADR;
      OP_WIDTH'(OP_RTYPE):                decodeTarget = S_EXECUTE;
      OP_WIDTH'(OP_BEQ):                  decodeTarget = S_BRANCH;
      OP_WIDTH'(OP_ADDI): if (HAS_ADDI) decodeTarget = S_ADDIEX; else opLegal = 1'b0;
      OP_WIDTH'(OP_J):    if (HAS_JUMP) decodeTarget = S_JUMP;   else opLegal = 1'b0;
      default:                            opLegal = 1'b0;
    endcase
    if (!opLegal) decodeTarget = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
  end

  assign skipIllegal = (state == S_DECODE) && !opLegal && !TRAP_ON_ILLEGAL;

  always_comb begin
    nextState = state;
    case (state)
      S_FETCH:   if (bus.mem_ready) nextState = S_DECODE;
      S_DECODE:  nextState = decodeTarget;
      S_MEMADR:  nextState = (opReg == OP_WIDTH'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (bus.mem_ready) nextState = S_MEMWB;
      S_MEMWR:   if (bus.mem_ready) nextState = S_FETCH;
      S_EXECUTE: nextState = S_ALUWB;
      S_ADDIEX:  nextState = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: nextState = S_FETCH;
      S_TRAP:    nextState = S_TRAP;
      default:   nextState = S_FETCH;
    endcase
  end

  mc_output_decode uDecode (
    .state       (state),
    .memReady    (bus.mem_ready),
    .skipIllegal (skipIllegal),
    .ctrl        (ctrl)
  );

  // Reset forces every output low even though the state is only updated
  // at the next edge.
  assign ctrlQ = reset ? '0 : ctrl;

  assign bus.pc_write   = ctrlQ.pcWrite;
  assign bus.branch     = ctrlQ.branch;
  assign bus.ir_write   = ctrlQ.irWrite;
  assign bus.iord       = ctrlQ.iord;
  assign bus.mem_read   = ctrlQ.memRead;
  assign bus.mem_write  = ctrlQ.memWrite;
  assign bus.reg_write  = ctrlQ.regWrite;
  assign bus.reg_dst    = ctrlQ.regDst;
  assign bus.mem_to_reg = ctrlQ.memToReg;
  assign bus.alu_src_a  = ctrlQ.aluSrcA;
  assign bus.alu_src_b  = ctrlQ.aluSrcB;
  assign bus.alu_op     = ctrlQ.aluOp;
  assign bus.pc_src     = ctrlQ.pcSrc;
  assign bus.instr_done = ctrlQ.instrDone;
  assign bus.illegal_op = trapFlag & ~reset;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. Two instances share inputs:
// dutA traps on illegal opcodes, dutB skips them as NOPs.
// Output word layout (18 bits):
// {pc_write,branch,ir_write,iord,mem_read,mem_write,reg_write,reg_dst,
//  mem_to_reg,alu_src_a,alu_src_b[1:0],alu_op[1:0],pc_src[1:0],instr_done,illegal_op}
module tb_multicycle_control_unit;
  import mips_mc_pkg::*;

  localparam logic [17:0] E_ZERO   = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] E_FETCHR = 18'b1_0_1_0_1_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] E_FETCHW = 18'b0_0_0_0_1_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] E_DEC    = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] E_DECSK  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_0;
  localparam logic [17:0] E_MEMADR = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] E_MEMRD  = 18'b0_0_0_1_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] E_MEMWB  = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [17:0] E_MEMWRW = 18'b0_0_0_1_0_1_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] E_MEMWRD = 18'b0_0_0_1_0_1_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] E_EXEC   = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] E_ALUWB  = 18'b0_0_0_0_0_0_1_1_0_0_00_00_00_1_0;
  localparam logic [17:0] E_BRANCH = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] E_ADDIWB = 18'b0_0_0_0_0_0_1_0_0_0_00_00_00_1_0;
  localparam logic [17:0] E_JUMP   = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [17:0] E_TRAP   = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;
  localparam logic [5:0]  OP_BAD   = 6'b111111;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [17:0] exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.OP_WIDTH(6)) busA ();
  multicycle_control_unit_if #(.OP_WIDTH(6)) busB ();

  assign busB.op        = busA.op;
  assign busB.mem_ready = busA.mem_ready;

  multicycle_control_unit #(.OP_WIDTH(6), .HAS_JUMP(1'b1), .HAS_ADDI(1'b1),
                            .TRAP_ON_ILLEGAL(1'b1))
    dutA (.clk(clk), .reset(reset), .bus(busA));
  multicycle_control_unit #(.OP_WIDTH(6), .HAS_JUMP(1'b1), .HAS_ADDI(1'b1),
                            .TRAP_ON_ILLEGAL(1'b0))
    dutB (.clk(clk), .reset(reset), .bus(busB));

  logic [17:0] actA, actB;
  assign actA = {busA.pc_write, busA.branch, busA.ir_write, busA.iord, busA.mem_read,
                 busA.mem_write, busA.reg_write, busA.reg_dst, busA.mem_to_reg,
                 busA.alu_src_a, busA.alu_src_b, busA.alu_op, busA.pc_src,
                 busA.instr_done, busA.illegal_op};
  assign actB = {busB.pc_write, busB.branch, busB.ir_write, busB.iord, busB.mem_read,
                 busB.mem_write, busB.reg_write, busB.reg_dst, busB.mem_to_reg,
                 busB.alu_src_a, busB.alu_src_b, busB.alu_op, busB.pc_src,
                 busB.instr_done, busB.illegal_op};

  int   nChecks = 0;
  int   nFails  = 0;
  vec_t tbl[$];

  task automatic addV(input logic r, input logic [5:0] o, input logic d,
                      input logic [17:0] e, input string n);
    vec_t v;
    v.rst = r; v.op = o; v.rdy = d; v.exp = e; v.name = n;
    tbl.push_back(v);
  endtask

  // Drive one cycle's inputs away from the edge, then let outputs settle.
  task automatic cyc(input logic r, input logic [5:0] o, input logic d);
    @(negedge clk);
    reset        = r;
    busA.op        = o;
    busA.mem_ready = d;
    #1;
  endtask

  task automatic chk(input string n, input logic [17:0] act, input logic [17:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask

  initial begin
    busA.op        = '0;
    busA.mem_ready = 1'b0;

    addV(1, OP_RTYPE, 1, E_ZERO,   "reset0");
    addV(1, OP_RTYPE, 1, E_ZERO,   "reset1");
    // R-type, beq, j back to back: retire in cycles 4, 7, 10
    addV(0, OP_RTYPE, 1, E_FETCHR, "r.fetch");
    addV(0, OP_RTYPE, 0, E_DEC,    "r.decode");
    addV(0, OP_BAD,   0, E_EXEC,   "r.execute");
    addV(0, OP_BAD,   1, E_ALUWB,  "r.aluwb");
    addV(0, OP_BEQ,   1, E_FETCHR, "beq.fetch");
    addV(0, OP_BEQ,   1, E_DEC,    "beq.decode");
    addV(0, OP_RTYPE, 0, E_BRANCH, "beq.branch");
    addV(0, OP_J,     1, E_FETCHR, "j.fetch");
    addV(0, OP_J,     1, E_DEC,    "j.decode");
    addV(0, OP_J,     0, E_JUMP,   "j.jump");
    // lw, mem always ready: 5 cycles
    addV(0, OP_LW,    1, E_FETCHR, "lw.fetch");
    addV(0, OP_LW,    1, E_DEC,    "lw.decode");
    addV(0, OP_BAD,   1, E_MEMADR, "lw.memadr");
    addV(0, OP_BAD,   1, E_MEMRD,  "lw.memrd");
    addV(0, OP_BAD,   1, E_MEMWB,  "lw.memwb");
    // sw with two wait states in MEMWR: 6 cycles
    addV(0, OP_SW,    1, E_FETCHR, "sw.fetch");
    addV(0, OP_SW,    1, E_DEC,    "sw.decode");
    addV(0, OP_RTYPE, 1, E_MEMADR, "sw.memadr");
    addV(0, OP_RTYPE, 0, E_MEMWRW, "sw.memwr.w1");
    addV(0, OP_RTYPE, 0, E_MEMWRW, "sw.memwr.w2");
    addV(0, OP_RTYPE, 1, E_MEMWRD, "sw.memwr.done");
    // three fetch wait states, then addi
    addV(0, OP_ADDI,  0, E_FETCHW, "addi.fetch.w1");
    addV(0, OP_ADDI,  0, E_FETCHW, "addi.fetch.w2");
    addV(0, OP_ADDI,  0, E_FETCHW, "addi.fetch.w3");
    addV(0, OP_ADDI,  1, E_FETCHR, "addi.fetch");
    addV(0, OP_ADDI,  0, E_DEC,    "addi.decode");
    addV(0, OP_SW,    0, E_MEMADR, "addi.ex");
    addV(0, OP_SW,    1, E_ADDIWB, "addi.wb");
    // reset taken while lw waits in MEMRD
    addV(0, OP_LW,    1, E_FETCHR, "rst.lw.fetch");
    addV(0, OP_LW,    1, E_DEC,    "rst.lw.decode");
    addV(0, OP_LW,    1, E_MEMADR, "rst.lw.memadr");
    addV(0, OP_LW,    0, E_MEMRD,  "rst.lw.memrd");
    addV(1, OP_LW,    1, E_ZERO,   "rst.in.memrd");
    addV(1, OP_LW,    1, E_ZERO,   "rst.hold");
    addV(0, OP_RTYPE, 1, E_FETCHR, "rst.next.fetch");
    addV(0, OP_RTYPE, 1, E_DEC,    "rst.next.decode");
    addV(0, OP_RTYPE, 1, E_EXEC,   "rst.next.execute");
    addV(0, OP_RTYPE, 1, E_ALUWB,  "rst.next.aluwb");

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].op, tbl[i].rdy);
      chk({tbl[i].name, ".A"}, actA, tbl[i].exp);
      chk({tbl[i].name, ".B"}, actB, tbl[i].exp);
    end

    // Illegal opcode: A traps from cycle 3 and holds, B skips back to FETCH.
    cyc(0, OP_BAD, 1);   chk("ill.fetch.A", actA, E_FETCHR);
                         chk("ill.fetch.B", actB, E_FETCHR);
    cyc(0, OP_BAD, 1);   chk("ill.decode.A", actA, E_DEC);
                         chk("ill.decode.B", actB, E_DECSK);
    cyc(0, OP_RTYPE, 1); chk("ill.trap.A", actA, E_TRAP);
                         chk("ill.skip.B", actB, E_FETCHR);
    for (int k = 0; k < 3; k++) begin
      cyc(0, OP_LW, logic'(k[0]));
      chk("ill.trap.hold.A", actA, E_TRAP);
    end
    cyc(1, OP_RTYPE, 1); chk("ill.reset.A", actA, E_ZERO);
                         chk("ill.reset.B", actB, E_ZERO);
    cyc(0, OP_RTYPE, 1); chk("ill.after.A", actA, E_FETCHR);
                         chk("ill.after.B", actB, E_FETCHR);
    cyc(0, OP_RTYPE, 1); chk("ill.after.dec.A", actA, E_DEC);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
